// File: rtl/pipe_reg_de_if.sv
// D->E pipeline register bus.
//   master : D-stage side, drives stall/flush and the d_* fields, observes e_*.
//   slave  : the pipeline register, takes stall/flush and d_*, drives e_*.
interface pipe_reg_de_if;
    logic        stall;
    logic        flush;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_rs_data;
    logic [31:0] d_rt_data;
    logic [31:0] d_ext;
    logic [4:0]  d_wreg;
    logic [1:0]  d_tnew;

    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_rs_data;
    logic [31:0] e_rt_data;
    logic [31:0] e_ext;
    logic [4:0]  e_wreg;
    logic [1:0]  e_tnew;
    logic        e_valid;

    modport master (
        output stall, flush,
        output d_instr, d_pc, d_rs_data, d_rt_data, d_ext, d_wreg, d_tnew,
        input  e_instr, e_pc, e_rs_data, e_rt_data, e_ext, e_wreg, e_tnew, e_valid
    );

    modport slave (
        input  stall, flush,
        input  d_instr, d_pc, d_rs_data, d_rt_data, d_ext, d_wreg, d_tnew,
        output e_instr, e_pc, e_rs_data, e_rt_data, e_ext, e_wreg, e_tnew, e_valid
    );
endinterface

// File: rtl/pipe_reg_de.sv
// D->E pipeline register with bubble insertion and stall/flush event counters.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low; clears all state, e_pc = RESET_PC
//   bus       : pipe_reg_de_if.slave (stall, flush, d_* in; e_* out)
//   stall_cnt : saturating count of edges with stall=1, flush=0
//   flush_cnt : saturating count of edges with flush=1
// Every enabled edge either loads the D-stage fields or inserts a bubble;
// there is no hold state.
module pipe_reg_de #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipe_reg_de_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       bubble;
    logic [1:0] tnew_next;

    assign bubble = bus.stall | bus.flush;

    // One cycle elapses crossing D->E; clamp at 0 so 0 never wraps to 3.
    always_comb begin
        tnew_next = 2'd0;
        if (bus.d_tnew != 2'd0) begin
            tnew_next = bus.d_tnew - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.e_instr   <= '0;
            bus.e_pc      <= RESET_PC;
            bus.e_rs_data <= '0;
            bus.e_rt_data <= '0;
            bus.e_ext     <= '0;
            bus.e_wreg    <= '0;
            bus.e_tnew    <= '0;
            bus.e_valid   <= 1'b0;
        end else if (bubble) begin
            // A bubble is an all-zero instruction with no destination, so it
            // causes no architectural write; the PC still tracks D for tracing.
            bus.e_instr   <= '0;
            bus.e_pc      <= bus.d_pc;
            bus.e_rs_data <= '0;
            bus.e_rt_data <= '0;
            bus.e_ext     <= '0;
            bus.e_wreg    <= '0;
            bus.e_tnew    <= '0;
            bus.e_valid   <= 1'b0;
        end else begin
            bus.e_instr   <= bus.d_instr;
            bus.e_pc      <= bus.d_pc;
            bus.e_rs_data <= bus.d_rs_data;
            bus.e_rt_data <= bus.d_rt_data;
            bus.e_ext     <= bus.d_ext;
            bus.e_wreg    <= bus.d_wreg;
            bus.e_tnew    <= tnew_next;
            bus.e_valid   <= 1'b1;
        end
    end

    // Flush takes precedence for accounting when both are asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.flush) begin
                if (flush_cnt != '1) begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                end
            end else if (bus.stall) begin
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_de.sv
module tb_pipe_reg_de;

    logic clk;
    logic reset;

    pipe_reg_de_if bus ();
    pipe_reg_de_if bus4 ();

    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;

    // The narrow-counter instance sees exactly the same D-stage stimulus.
    assign bus4.stall     = bus.stall;
    assign bus4.flush     = bus.flush;
    assign bus4.d_instr   = bus.d_instr;
    assign bus4.d_pc      = bus.d_pc;
    assign bus4.d_rs_data = bus.d_rs_data;
    assign bus4.d_rt_data = bus.d_rt_data;
    assign bus4.d_ext     = bus.d_ext;
    assign bus4.d_wreg    = bus.d_wreg;
    assign bus4.d_tnew    = bus.d_tnew;

    pipe_reg_de #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_reg_de #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [4:0]  wreg;
        logic [1:0]  tnew;
        logic        valid;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [3:0]  scnt4;
        logic [3:0]  fcnt4;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference counter state.
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;
    int          m_scnt4;
    int          m_fcnt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".e_instr"},   bus.e_instr,   32'h0);
        chk({tag, ".e_pc"},      bus.e_pc,      32'h0000_3000);
        chk({tag, ".e_rs_data"}, bus.e_rs_data, 32'h0);
        chk({tag, ".e_rt_data"}, bus.e_rt_data, 32'h0);
        chk({tag, ".e_ext"},     bus.e_ext,     32'h0);
        chk({tag, ".e_wreg"},    32'(bus.e_wreg),  32'h0);
        chk({tag, ".e_tnew"},    32'(bus.e_tnew),  32'h0);
        chk({tag, ".e_valid"},   32'(bus.e_valid), 32'h0);
        chk({tag, ".stall_cnt"}, stall_cnt, 32'h0);
        chk({tag, ".flush_cnt"}, flush_cnt, 32'h0);
        chk({tag, ".stall_cnt4"}, 32'(stall_cnt4), 32'h0);
        chk({tag, ".flush_cnt4"}, 32'(flush_cnt4), 32'h0);
        chk({tag, ".dut4.e_pc"}, bus4.e_pc, 32'h0000_3000);
    endtask

    // Drive one D-stage vector for the next edge and queue the E-stage response.
    task automatic step(input logic st, input logic fl,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ext, input logic [4:0] wreg,
                        input logic [1:0] tnew);
        exp_t e;
        @(negedge clk);
        bus.stall     = st;
        bus.flush     = fl;
        bus.d_instr   = instr;
        bus.d_pc      = pc;
        bus.d_rs_data = rs;
        bus.d_rt_data = rt;
        bus.d_ext     = ext;
        bus.d_wreg    = wreg;
        bus.d_tnew    = tnew;
        if (st || fl) begin
            e.instr = 32'h0; e.rs = 32'h0; e.rt = 32'h0; e.ext = 32'h0;
            e.wreg = 5'd0; e.tnew = 2'd0; e.valid = 1'b0;
        end else begin
            e.instr = instr; e.rs = rs; e.rt = rt; e.ext = ext;
            e.wreg = wreg; e.valid = 1'b1;
            case (tnew)
                2'd0:    e.tnew = 2'd0;
                2'd1:    e.tnew = 2'd0;
                2'd2:    e.tnew = 2'd1;
                default: e.tnew = 2'd2;
            endcase
        end
        e.pc = pc;
        if (fl) begin
            if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
            if (m_fcnt4 < 15) m_fcnt4++;
        end else if (st) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
            if (m_scnt4 < 15) m_scnt4++;
        end
        e.scnt  = m_scnt;
        e.fcnt  = m_fcnt;
        e.scnt4 = 4'(m_scnt4);
        e.fcnt4 = 4'(m_fcnt4);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: after every edge, compare the presented E-stage state to the
    // oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("e_instr",    bus.e_instr,   e.instr);
            chk("e_pc",       bus.e_pc,      e.pc);
            chk("e_rs_data",  bus.e_rs_data, e.rs);
            chk("e_rt_data",  bus.e_rt_data, e.rt);
            chk("e_ext",      bus.e_ext,     e.ext);
            chk("e_wreg",     32'(bus.e_wreg),  32'(e.wreg));
            chk("e_tnew",     32'(bus.e_tnew),  32'(e.tnew));
            chk("e_valid",    32'(bus.e_valid), 32'(e.valid));
            chk("stall_cnt",  stall_cnt, e.scnt);
            chk("flush_cnt",  flush_cnt, e.fcnt);
            chk("stall_cnt4", 32'(stall_cnt4), 32'(e.scnt4));
            chk("flush_cnt4", 32'(flush_cnt4), 32'(e.fcnt4));
            chk("dut4.e_instr", bus4.e_instr, e.instr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 0; m_fcnt4 = 0;
        reset         = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.d_instr   = 32'h0;
        bus.d_pc      = 32'h0;
        bus.d_rs_data = 32'h0;
        bus.d_rt_data = 32'h0;
        bus.d_ext     = 32'h0;
        bus.d_wreg    = 5'd0;
        bus.d_tnew    = 2'd0;

        #23;
        check_reset_state("rst_init");
        @(posedge clk); #2; reset = 1'b1;

        // First edge after release: ori load.
        step(0, 0, 32'h3421_0005, 32'h3004, 32'h1111_1111, 32'h2222_2222, 32'h0000_0005, 5'd1, 2'd2);
        // tnew boundaries.
        step(0, 0, 32'h0043_0821, 32'h3008, 32'hAAAA_0001, 32'h5555_0002, 32'hFFFF_FFF0, 5'd3, 2'd0);
        step(0, 0, 32'h8C22_0004, 32'h300C, 32'h0000_0010, 32'h0000_0020, 32'h0000_0004, 5'd2, 2'd3);
        step(0, 0, 32'h0062_2023, 32'h3010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0000, 5'd31, 2'd1);
        // Three stall edges at pc 3008.
        for (int i = 0; i < 3; i++)
            step(1, 0, 32'h3425_0007, 32'h3008, 32'h1234_5678, 32'h8765_4321, 32'h0000_0007, 5'd5, 2'd2);
        // Stall and flush together, then flush alone.
        step(1, 1, 32'h1000_0003, 32'h3014, 32'h1, 32'h2, 32'h3, 5'd4, 2'd1);
        step(0, 1, 32'h1000_0004, 32'h3018, 32'h4, 32'h5, 32'h6, 5'd6, 2'd2);
        step(0, 0, 32'h2408_FFFF, 32'h301C, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd8, 2'd2);
        // Long runs to saturate the 4-bit counters.
        for (int i = 0; i < 20; i++)
            step(1, 0, 32'hFFFF_FFFF, 32'h3100 + 32'(i * 4), 32'h9, 32'h9, 32'h9, 5'd9, 2'd3);
        for (int i = 0; i < 17; i++)
            step(0, 1, 32'hFFFF_FFFF, 32'h3200 + 32'(i * 4), 32'h9, 32'h9, 32'h9, 5'd9, 2'd3);
        // Load leaving e_valid=1, then reset mid-cycle with stall/flush high.
        step(0, 0, 32'h3421_0005, 32'h3300, 32'h77, 32'h88, 32'h5, 5'd1, 2'd2);
        #2;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        reset = 1'b0;
        #1;
        check_reset_state("rst_async");
        m_scnt = 32'd0; m_fcnt = 32'd0; m_scnt4 = 0; m_fcnt4 = 0;
        @(posedge clk); #1;
        check_reset_state("rst_hold");
        @(posedge clk); #2; reset = 1'b1;

        // First edge after the second release is an ordinary load.
        step(0, 0, 32'h3C01_1234, 32'h3400, 32'hABCD_0000, 32'h0000_ABCD, 32'h1234_0000, 5'd1, 2'd2);
        step(1, 0, 32'h3C01_1234, 32'h3404, 32'h1, 32'h1, 32'h1, 5'd1, 2'd2);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
